// File: rtl/lock_gated_video_timing.sv
// Video timing generator gated by a qualified PLL lock.
// Timing restarts from h=0,v=0 after every lock loss.
module lock_gated_video_timing #(
  parameter int H_ACTIVE  = 320,
  parameter int H_FP      = 20,
  parameter int H_SYNC    = 10,
  parameter int H_BP      = 30,
  parameter int V_ACTIVE  = 240,
  parameter int V_FP      = 4,
  parameter int V_SYNC    = 2,
  parameter int V_BP      = 6,
  parameter int LOCK_WAIT = 1024,
  parameter bit SYNC_POL  = 1'b0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        pll_lock,
  output logic        ready,
  output logic        hsync,
  output logic        vsync,
  output logic        de,
  output logic [10:0] x,
  output logic [9:0]  y,
  output logic        line_start,
  output logic        frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int WW = (LOCK_WAIT > 1) ? $clog2(LOCK_WAIT) : 1;

  if (H_TOTAL > 2048 || V_TOTAL > 1024 || LOCK_WAIT < 1) begin : g_bad_cfg
    $error("lock_gated_video_timing: illegal timing parameters");
  end

  localparam logic [10:0] H_LAST = 11'(H_TOTAL - 1);
  localparam logic [9:0]  V_LAST = 10'(V_TOTAL - 1);
  localparam logic [11:0] H_ACT  = 12'(H_ACTIVE);
  localparam logic [11:0] HS_BEG = 12'(H_ACTIVE + H_FP);
  localparam logic [11:0] HS_END = 12'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [10:0] V_ACT  = 11'(V_ACTIVE);
  localparam logic [10:0] VS_BEG = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0] VS_END = 11'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [WW-1:0] WAIT_LAST = WW'(LOCK_WAIT - 1);

  typedef enum logic [1:0] {
    WAIT_LOCK,
    STABLE,
    RUN
  } state_t;

  state_t state, next;

  logic          lock_meta, lock_s;
  logic [WW-1:0] wait_cnt;
  logic [10:0]   h_cnt;
  logic [9:0]    v_cnt;

  // Only place PLL_LOCK is sampled.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lock_meta <= 1'b0;
      lock_s    <= 1'b0;
    end else begin
      lock_meta <= pll_lock;
      lock_s    <= lock_meta;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= WAIT_LOCK;
    else       state <= next;
  end

  always_comb begin
    next = state;
    unique case (state)
      WAIT_LOCK: if (lock_s) next = STABLE;
      STABLE: begin
        if (!lock_s)                     next = WAIT_LOCK;
        else if (wait_cnt == WAIT_LAST)  next = RUN;
      end
      RUN:     if (!lock_s) next = WAIT_LOCK;
      default: next = WAIT_LOCK;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wait_cnt <= '0;
      h_cnt    <= '0;
      v_cnt    <= '0;
    end else begin
      if (state == STABLE && lock_s && wait_cnt != WAIT_LAST)
        wait_cnt <= wait_cnt + 1'b1;
      else
        wait_cnt <= '0;
      // Counters sit at zero outside RUN, so RUN always starts at 0,0.
      if (state == RUN && lock_s) begin
        if (h_cnt == H_LAST) begin
          h_cnt <= '0;
          v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
        end else begin
          h_cnt <= h_cnt + 1'b1;
        end
      end else begin
        h_cnt <= '0;
        v_cnt <= '0;
      end
    end
  end

  logic h_act, v_act, h_sync_win, v_sync_win, act;

  always_comb begin
    h_act      = {1'b0, h_cnt} < H_ACT;
    v_act      = {1'b0, v_cnt} < V_ACT;
    h_sync_win = ({1'b0, h_cnt} >= HS_BEG) && ({1'b0, h_cnt} < HS_END);
    v_sync_win = ({1'b0, v_cnt} >= VS_BEG) && ({1'b0, v_cnt} < VS_END);
    act        = h_act && v_act;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ready       <= 1'b0;
      hsync       <= ~SYNC_POL;
      vsync       <= ~SYNC_POL;
      de          <= 1'b0;
      x           <= '0;
      y           <= '0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      ready <= (next == RUN);
      if (state == RUN) begin
        hsync       <= h_sync_win ? SYNC_POL : ~SYNC_POL;
        vsync       <= v_sync_win ? SYNC_POL : ~SYNC_POL;
        de          <= act;
        x           <= act ? h_cnt : '0;
        y           <= act ? v_cnt : '0;
        line_start  <= (h_cnt == '0);
        frame_start <= (h_cnt == '0) && (v_cnt == '0);
      end else begin
        hsync       <= ~SYNC_POL;
        vsync       <= ~SYNC_POL;
        de          <= 1'b0;
        x           <= '0;
        y           <= '0;
        line_start  <= 1'b0;
        frame_start <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_lock_gated_video_timing.sv
// Bench for lock_gated_video_timing: two configurations
// checked each cycle against a lock-streak reference model.
module tb_lock_gated_video_timing;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic lock_a = 1'b0;
  logic lock_b = 1'b0;

  always #5 clk = ~clk;

  logic        rdy_a, hs_a, vs_a, de_a, ls_a, fs_a;
  logic [10:0] x_a;
  logic [9:0]  y_a;
  logic        rdy_b, hs_b, vs_b, de_b, ls_b, fs_b;
  logic [10:0] x_b;
  logic [9:0]  y_b;

  lock_gated_video_timing #(
    .V_ACTIVE(8), .V_FP(2), .V_SYNC(2), .V_BP(2),
    .LOCK_WAIT(16), .SYNC_POL(1'b0)
  ) dut_a (
    .clk(clk), .reset(rst), .pll_lock(lock_a),
    .ready(rdy_a), .hsync(hs_a), .vsync(vs_a), .de(de_a),
    .x(x_a), .y(y_a),
    .line_start(ls_a), .frame_start(fs_a)
  );

  lock_gated_video_timing #(
    .H_ACTIVE(2), .H_FP(1), .H_SYNC(1), .H_BP(1),
    .V_ACTIVE(2), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .LOCK_WAIT(3), .SYNC_POL(1'b1)
  ) dut_b (
    .clk(clk), .reset(rst), .pll_lock(lock_b),
    .ready(rdy_b), .hsync(hs_b), .vsync(vs_b), .de(de_b),
    .x(x_b), .y(y_b),
    .line_start(ls_b), .frame_start(fs_b)
  );

  logic [26:0] vec_a, vec_b;
  assign vec_a = {rdy_a, hs_a, vs_a, de_a, x_a, y_a, ls_a, fs_a};
  assign vec_b = {rdy_b, hs_b, vs_b, de_b, x_b, y_b, ls_b, fs_b};

  int c_ha[2] = '{320, 2};
  int c_hf[2] = '{20, 1};
  int c_hs[2] = '{10, 1};
  int c_hb[2] = '{30, 1};
  int c_va[2] = '{8, 2};
  int c_vf[2] = '{2, 1};
  int c_vs[2] = '{2, 1};
  int c_vb[2] = '{2, 1};
  int c_lw[2] = '{16, 3};
  bit c_pol[2] = '{1'b0, 1'b1};

  // Model: streak = consecutive synchronised-lock cycles seen.
  // RUN once streak exceeds LOCK_WAIT; frame position follows.
  int streak[2];
  bit m1[2], m2[2];
  int vecs = 0;
  int fails = 0;
  int cyc = 0;

  function automatic logic [26:0] expect_vec(int i, bit run,
                                             int pos, bit rdy);
    int ht, vt, h, v, hs0, vs0;
    bit act;
    logic p, hs, vs;
    p  = c_pol[i];
    ht = c_ha[i] + c_hf[i] + c_hs[i] + c_hb[i];
    vt = c_va[i] + c_vf[i] + c_vs[i] + c_vb[i];
    if (!run) return {rdy, ~p, ~p, 1'b0, 11'd0, 10'd0, 2'b00};
    h   = pos % ht;
    v   = (pos / ht) % vt;
    hs0 = c_ha[i] + c_hf[i];
    vs0 = c_va[i] + c_vf[i];
    act = (h < c_ha[i]) && (v < c_va[i]);
    hs  = (h >= hs0 && h < hs0 + c_hs[i]) ? p : ~p;
    vs  = (v >= vs0 && v < vs0 + c_vs[i]) ? p : ~p;
    return {rdy, hs, vs, act,
            act ? 11'(h) : 11'd0,
            act ? 10'(v) : 10'd0,
            h == 0, (h == 0) && (v == 0)};
  endfunction

  function automatic logic [26:0] obs_vec(int i);
    return (i == 0) ? vec_a : vec_b;
  endfunction

  task automatic chk(string tag, int o, int e);
    vecs++;
    assert (o === e) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, o, e);
    end
  endtask

  task automatic tick();
    logic [26:0] ev [2];
    bit lk, pr;
    int pp;
    @(posedge clk);
    for (int i = 0; i < 2; i++) begin
      lk = (i == 0) ? lock_a : lock_b;
      if (rst) begin
        streak[i] = 0;
        m1[i] = 1'b0;
        m2[i] = 1'b0;
        ev[i] = expect_vec(i, 1'b0, 0, 1'b0);
      end else begin
        pr = streak[i] > c_lw[i];
        pp = streak[i] - c_lw[i] - 1;
        streak[i] = m2[i] ? streak[i] + 1 : 0;
        m2[i] = m1[i];
        m1[i] = lk;
        ev[i] = expect_vec(i, pr, pp, streak[i] > c_lw[i]);
      end
    end
    #1;
    cyc++;
    for (int i = 0; i < 2; i++) begin
      vecs++;
      assert (obs_vec(i) === ev[i]) else begin
        fails++;
        $error("FAIL cycle%0d dut%0d observed=%h expected=%h",
               cyc, i, obs_vec(i), ev[i]);
      end
    end
  endtask

  function automatic bit sig(int s);
    case (s)
      0: return fs_a;
      1: return ls_a;
      2: return hs_a == 1'b0;
      3: return de_a;
      4: return fs_b;
      5: return rdy_a;
      6: return !rdy_a;
      7: return vs_a == 1'b0;
      8: return de_a && x_a == 11'd150 && y_a == 10'd3;
      default: return 1'b0;
    endcase
  endfunction

  task automatic wait_for(string tag, int s, int limit,
                          output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!sig(s) && n < limit);
    chk({tag, "_seen"}, int'(sig(s)), 1);
  endtask

  task automatic count_while(int s, int limit, output int n);
    n = 0;
    while (sig(s) && n < limit) begin
      tick();
      n++;
    end
  endtask

  int n, f0;

  initial begin
    #1 rst = 1'b1;
    #1;
    chk("reset_a", int'(vec_a), int'(expect_vec(0, 1'b0, 0, 1'b0)));
    chk("reset_b", int'(vec_b), int'(expect_vec(1, 1'b0, 0, 1'b0)));
    repeat (3) tick();
    #2 rst = 1'b0;
    repeat (5) tick();

    // Lock qualification: READY 19 edges after the rise.
    lock_a = 1'b1;
    lock_b = 1'b1;
    wait_for("lock_qual", 5, 100, n);
    chk("lock_qual_edges", n, 19);
    tick();
    chk("first_px", int'({fs_a, de_a, x_a, y_a}),
        int'({2'b11, 21'd0}));
    f0 = cyc;

    // Line and sync geometry.
    wait_for("line", 1, 400, n);
    chk("line_period", n, 380);
    wait_for("hsync", 2, 400, n);
    chk("hs_offset", n, 340);
    count_while(2, 50, n);
    chk("hs_width", n, 10);
    wait_for("frame", 0, 6000, n);
    chk("frame_period", cyc - f0, 380 * 14);
    wait_for("vsync", 7, 6000, n);
    count_while(7, 2000, n);
    chk("vs_width", n, 760);

    // Minimal active-high config.
    wait_for("fs_b0", 4, 100, n);
    wait_for("fs_b1", 4, 100, n);
    chk("b_frame_period", n, 25);

    // Lock loss mid-line, then a fresh frame after re-lock.
    wait_for("x150", 8, 6000, n);
    lock_a = 1'b0;
    wait_for("loss", 6, 10, n);
    chk("loss_latency", n, 3);
    tick();
    chk("idle_after_loss", int'(vec_a),
        int'(expect_vec(0, 1'b0, 0, 1'b0)));
    lock_a = 1'b1;
    wait_for("relock", 5, 100, n);
    chk("relock_edges", n, 19);
    tick();
    chk("relock_px", int'({fs_a, de_a, x_a, y_a}),
        int'({2'b11, 21'd0}));

    // Glitch during qualification restarts the full wait.
    lock_a = 1'b0;
    wait_for("drop", 6, 10, n);
    repeat (10) tick();
    lock_a = 1'b1;
    repeat (13) tick();
    lock_a = 1'b0;
    repeat (3) tick();
    lock_a = 1'b1;
    wait_for("glitch", 5, 100, n);
    chk("glitch_edges", n, 19);

    // Random lock activity.
    for (int seg = 0; seg < 30; seg++) begin
      lock_a = ($urandom_range(0, 3) != 0);
      lock_b = ($urandom_range(0, 3) != 0);
      repeat ($urandom_range(1, 200)) tick();
    end

    // Asynchronous reset mid-RUN.
    lock_a = 1'b1;
    lock_b = 1'b1;
    repeat (40) tick();
    wait_for("pre_rst", 5, 100, n);
    repeat (50) tick();
    #2 rst = 1'b1;
    #1;
    chk("async_rst_a", int'(vec_a),
        int'(expect_vec(0, 1'b0, 0, 1'b0)));
    chk("async_rst_b", int'(vec_b),
        int'(expect_vec(1, 1'b0, 0, 1'b0)));
    tick();
    lock_a = 1'b0;
    lock_b = 1'b0;
    #2 rst = 1'b0;
    repeat (100) tick();
    chk("idle_no_lock", int'({rdy_a, de_a, rdy_b, de_b}), 0);

    $display("== %0d vectors applied, %0d miscompares ==",
             vecs, fails);
    $finish;
  end

endmodule

// File: doc/lock_gated_video_timing.md
# lock_gated_video_timing

Video timing generator clocked by the 54 MHz global PLL output. It waits for the PLL to report lock and for that lock to stay stable for a programmable number of cycles. It then produces hsync/vsync/data-enable, pixel coordinates and frame/line strobes for the frame-buffer read port and the DPHY packetiser. Any loss of lock stops timing immediately and restarts the lock qualification.

## Interface
- H_ACTIVE, 320, active pixels per line
- H_FP, 20, horizontal front porch (cycles)
- H_SYNC, 10, hsync width (cycles)
- H_BP, 30, horizontal back porch (cycles)
- V_ACTIVE, 240, active lines per frame
- V_FP, 4, vertical front porch (lines)
- V_SYNC, 2, vsync width (lines)
- V_BP, 6, vertical back porch (lines)
- LOCK_WAIT, 1024, consecutive synchronised-lock cycles required before RUN (≥1)
- SYNC_POL, 0, sync polarity: 0 = active-low, 1 = active-high
- CLK  in  1  pixel clock (PLLOUTGLOBALA, 54 MHz)
- RESET  in  1  asynchronous, active-high; one clock domain only
- PLL_LOCK  in  1  PLL LOCK output, asynchronous to CLK
- READY  out  1  high while FSM is in RUN
- HSYNC  out  1  horizontal sync, polarity per SYNC_POL
- VSYNC  out  1  vertical sync, polarity per SYNC_POL
- DE  out  1  active-video enable
- X  out  11  pixel column, valid when DE=1
- Y  out  10  pixel row, valid when DE=1
- LINE_START  out  1  one-cycle pulse at the first cycle of every line (h=0)
- FRAME_START  out  1  one-cycle pulse at h=0, v=0

## Operation
- PLL_LOCK passes through a 2-flop synchroniser to give lock_s. No other logic samples PLL_LOCK directly.
- Derived totals:
  - H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP, at most 2048.
  - V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP, at most 1024.
  - Violating either bound is an elaboration error.
- Horizontal order within a line: active [0, H_ACTIVE), front porch, sync [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC), back porch. The vertical order is the same, counted in lines.
- FSM states:
  - WAIT_LOCK: wait_cnt=0, h_cnt=0, v_cnt=0. Go to STABLE when lock_s=1.
  - STABLE: wait_cnt increments each cycle with lock_s=1. If lock_s=0, return to WAIT_LOCK and clear wait_cnt. When wait_cnt=LOCK_WAIT-1 with lock_s=1, go to RUN.
  - RUN: h_cnt counts 0..H_TOTAL-1 and wraps to 0. On an h wrap, v_cnt counts 0..V_TOTAL-1 and wraps to 0. If lock_s=0, go to WAIT_LOCK and clear both counters in the same edge; this holds anywhere in the frame.
- Counters are 0 on the entry cycle to RUN. The first RUN cycle is therefore h=0, v=0.
- Outputs are decoded from h_cnt/v_cnt and registered, so they lag the counters by one cycle.
- HSYNC is asserted during the h sync window on every line, including vertical blanking lines. VSYNC is asserted for whole lines in the v sync window.
- DE = (h_cnt < H_ACTIVE) and (v_cnt < V_ACTIVE). X = h_cnt and Y = v_cnt, registered alongside DE. X and Y are 0 when DE=0.
- Outside RUN (including the cycle that leaves RUN), registered outputs take idle values on the next edge: DE=0, HSYNC and VSYNC deasserted, strobes 0, X=0, Y=0.

## Timing
- Reset values (asynchronous):
  - State WAIT_LOCK, all counters 0.
  - READY=0, DE=0, LINE_START=0, FRAME_START=0, X=0, Y=0.
  - HSYNC and VSYNC = ~SYNC_POL (deasserted).
  - Synchroniser flops 0.
- PLL_LOCK rise to READY rise: 2 cycles of synchroniser, 1 cycle into STABLE, then LOCK_WAIT cycles. Total 3+LOCK_WAIT edges, deterministic once PLL_LOCK meets setup.
- READY is a registered state decode. It rises on the RUN entry edge.
- The first FRAME_START, LINE_START and DE=1 (X=0, Y=0) appear one cycle after READY rises.
- LINE_START period is H_TOTAL cycles. FRAME_START period is H_TOTAL·V_TOTAL cycles; with defaults, 380·252 = 95760.
- DE is high for H_ACTIVE consecutive cycles per active line. HSYNC pulse width is H_SYNC cycles. VSYNC width is V_SYNC·H_TOTAL cycles.
- The HSYNC leading edge occurs H_ACTIVE+H_FP cycles after LINE_START.
- Lock loss: PLL_LOCK falling → READY falls 3 edges later, and the idle outputs appear 1 cycle after READY falls.
- A partial frame is never resumed. Re-lock always restarts at h=0, v=0 after a full LOCK_WAIT.

## Test plan
- Reset: assert RESET mid-RUN asynchronously → all outputs take their reset values without waiting for a clock edge. After release with PLL_LOCK=0 held for 100 cycles → READY stays 0 and DE stays 0.
- Lock qualification: LOCK_WAIT=16, PLL_LOCK rises at edge N → READY=1 at edge N+19. FRAME_START and DE with X=0, Y=0 at edge N+20.
- Lock glitch in STABLE: PLL_LOCK low for 3 cycles at wait_cnt=10 → READY rises exactly 19 edges after the final PLL_LOCK rise.
- Line/frame timing with defaults:
  - DE high for 320 cycles per line and 240 lines.
  - HSYNC low for 10 cycles starting 340 cycles after LINE_START.
  - VSYNC low for 760 cycles.
  - FRAME_START spacing 95760 cycles.
  - X runs 0..319 and Y runs 0..239 without gaps.
- Lock loss mid-line: drop PLL_LOCK at X=150, Y=100 → READY=0 after 3 edges, all outputs idle next cycle. After re-lock, the first frame begins at X=0, Y=0.
- SYNC_POL=1 and the minimal config (all porches 1, active 2×2) → HSYNC/VSYNC active-high. Totals are H=5 and V=5, giving FRAME_START spacing 25 cycles.
